rf_wb_arbiter: RTL

Write-port arbiter and pending-write scoreboard for the decode-stage 32x32 register file. It shares the register file's single write port between the in-order pipeline writeback (WB) and the multi-cycle multiply/divide unit (MDU). It buffers a colliding MDU result in a one-entry hold register. It also tracks registers with MDU results still in flight, so hazard logic can stall dependent reads.

---
 rtl/rv_pkg.sv | 32 +++
 rtl/rf_wb_arbiter_if.sv | 46 ++++
 rtl/rf_busy_scoreboard.sv | 40 ++++
 rtl/rf_wb_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Register-file constants, write-port bundle and helpers shared by the
// writeback arbiter and its busy scoreboard.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } rf_wr_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } hold_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_WB,
    SEL_HOLD,
    SEL_MD
  } wr_sel_e;

  // x0 is never a real destination.
  function automatic logic rd_live(input logic [REG_AW-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of writeback, MDU, issue, hazard-lookup and register-file write
// signals around rf_wb_arbiter.
interface rf_wb_arbiter_if;
  import rv_pkg::*;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              md_valid;
  logic              md_ready;
  logic [REG_AW-1:0] md_rd;
  logic [XLEN-1:0]   md_data;

  logic              iss_valid;
  logic [REG_AW-1:0] iss_rd;

  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wd;
  logic              stall_req;

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  md_valid, md_rd, md_data,
    input  iss_valid, iss_rd,
    input  rs1_addr, rs2_addr,
    output md_ready, rs1_busy, rs2_busy,
    output rf_we, rf_waddr, rf_wd, stall_req
  );

  modport master (
    output wb_valid, wb_rd, wb_data,
    output md_valid, md_rd, md_data,
    output iss_valid, iss_rd,
    output rs1_addr, rs2_addr,
    input  md_ready, rs1_busy, rs2_busy,
    input  rf_we, rf_waddr, rf_wd, stall_req
  );

endinterface

// File: rtl/rf_busy_scoreboard.sv
// Pending-MDU-write vector: one bit per register, x0 never busy, with two
// combinational lookup ports for decode.
module rf_busy_scoreboard
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_a = busy_q[rd_addr_a];
  assign busy_b = busy_q[rd_addr_b];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline WB and the MDU, with a
// one-entry MDU hold register. Define RF_WB_STARVE_GUARD_EN to add the
// hold starvation counter and stall_req.
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);

  logic              hold_valid_q;
  hold_t             hold_q;
  rf_wr_t            wr_q;
  rf_wr_t            wr_d;
  wr_sel_e           sel;
  logic              wb_eff;
  logic              md_acc;
  logic              md_live;
  logic              hold_load;
  logic              drain;
  logic              md_commit;
  logic [REG_AW-1:0] commit_rd;

  assign wb_eff       = bus.wb_valid && rd_live(bus.wb_rd);
  assign bus.md_ready = rst && !hold_valid_q;
  assign md_acc       = bus.md_valid && bus.md_ready;
  // Accepted x0 results are acknowledged and dropped here.
  assign md_live      = md_acc && rd_live(bus.md_rd);

  always_comb begin
    sel = SEL_NONE;
    if (wb_eff) begin
      sel = SEL_WB;
    end else if (hold_valid_q) begin
      sel = SEL_HOLD;
    end else if (md_live) begin
      sel = SEL_MD;
    end
  end

  assign hold_load = wb_eff && md_live;
  assign drain     = (sel == SEL_HOLD);

  always_comb begin
    wr_d      = '0;
    md_commit = 1'b0;
    commit_rd = '0;
    case (sel)
      SEL_WB: begin
        wr_d = '{we: 1'b1, addr: bus.wb_rd, data: bus.wb_data};
      end
      SEL_HOLD: begin
        wr_d      = '{we: 1'b1, addr: hold_q.rd, data: hold_q.data};
        md_commit = 1'b1;
        commit_rd = hold_q.rd;
      end
      SEL_MD: begin
        wr_d      = '{we: 1'b1, addr: bus.md_rd, data: bus.md_data};
        md_commit = 1'b1;
        commit_rd = bus.md_rd;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q         <= '0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      wr_q <= wr_d;
      if (hold_load) begin
        hold_valid_q <= 1'b1;
        hold_q       <= '{rd: bus.md_rd, data: bus.md_data};
      end else if (drain) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rf_we    = wr_q.we;
  assign bus.rf_waddr = wr_q.addr;
  assign bus.rf_wd    = wr_q.data;

  rf_busy_scoreboard u_busy (
    .clk       (clk),
    .rst       (rst),
    .set_en    (bus.iss_valid && rd_live(bus.iss_rd)),
    .set_addr  (bus.iss_rd),
    .clr_en    (md_commit),
    .clr_addr  (commit_rd),
    .rd_addr_a (bus.rs1_addr),
    .rd_addr_b (bus.rs2_addr),
    .busy_a    (bus.rs1_busy),
    .busy_b    (bus.rs2_busy)
  );

`ifdef RF_WB_STARVE_GUARD_EN
  localparam int CW = 4;

  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_d;
  logic          stall_q;

  // Counts held-but-not-drained cycles, saturating at MAX_WAIT.
  always_comb begin
    wait_d = wait_q;
    if (drain) begin
      wait_d = '0;
    end else if (hold_valid_q && (wait_q < CW'(MAX_WAIT))) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= (wait_d >= CW'(MAX_WAIT));
    end
  end

  assign bus.stall_req = stall_q;
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);
  assign bus.stall_req   = 1'b0;
`endif

endmodule
